// File: rtl/jtag_uart_master_if.sv
// -----------------------------------------------------------------------------
// jtag_uart_master_if
// Bundles the Avalon-MM master port towards a JTAG UART slave together with
// the byte-stream tx/rx handshakes of jtag_uart_master.
//   master modport : view of jtag_uart_master
//     avm_*   : Avalon-MM chipselect/address/read_n/write_n/writedata out,
//               readdata/waitrequest in
//     tx_*    : byte stream into the master (tx_data/tx_valid in, tx_ready out)
//     rx_*    : byte stream out of the master (rx_data/rx_valid out, rx_ready in)
//   slave modport  : view of the Avalon slave plus the stream producer/consumer
// -----------------------------------------------------------------------------
interface jtag_uart_master_if;
    logic        avm_chipselect;
    logic        avm_address;
    logic        avm_read_n;
    logic [31:0] avm_readdata;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;

    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport master (
        output avm_chipselect, avm_address, avm_read_n, avm_write_n, avm_writedata,
        input  avm_readdata, avm_waitrequest,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        input  rx_ready
    );

    modport slave (
        input  avm_chipselect, avm_address, avm_read_n, avm_write_n, avm_writedata,
        output avm_readdata, avm_waitrequest,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/jtag_uart_master.sv
// -----------------------------------------------------------------------------
// jtag_uart_master
// Avalon-MM master that moves bytes between a one-entry tx/rx holding register
// pair and a JTAG UART slave. It caches the slave's free TX space (wspace) and
// polls the control/data registers with a back-off timer when nothing is
// available.
//   clk_clk     : system clock, rising edge
//   reset_reset : synchronous active-high reset
//   bus         : jtag_uart_master_if.master (Avalon-MM + tx/rx byte streams)
// Parameter POLL_INTERVAL (2..65535): idle cycles between unproductive polls.
// -----------------------------------------------------------------------------
module jtag_uart_master #(
    parameter int unsigned POLL_INTERVAL = 64
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    jtag_uart_master_if.master    bus
);

    localparam logic [15:0] TimerLoad = 16'(POLL_INTERVAL - 1);

    typedef enum logic [1:0] {StIdle, StWrData, StRdCtrl, StRdData} state_e;

    state_e      r_state;
    state_e      w_state_d;

    logic        r_chipselect;
    logic        r_address;
    logic        r_read_n;
    logic        r_write_n;
    logic [31:0] r_writedata;

    logic        r_tx_full;
    logic [7:0]  r_tx_data;
    logic        r_rx_full;
    logic [7:0]  r_rx_data;
    logic [15:0] r_wspace;
    logic [15:0] r_timer;

    logic        w_done;
    logic        w_tx_fire;
    logic        w_rx_pop;
    logic        w_expired;
    logic        w_rvalid;
    logic [15:0] w_rd_hi;
    logic        w_unused_rdata;

    assign w_done    = (r_state != StIdle) && !bus.avm_waitrequest;
    assign w_tx_fire = bus.tx_valid && !r_tx_full;
    assign w_rx_pop  = r_rx_full && bus.rx_ready;
    assign w_expired = (r_timer == 16'd0);
    assign w_rvalid  = bus.avm_readdata[15];
    assign w_rd_hi   = bus.avm_readdata[31:16];
    assign w_unused_rdata = ^bus.avm_readdata[14:8];

    // State register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state: IDLE arbitrates write > control poll > data poll
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (r_tx_full && (r_wspace != 16'd0)) begin
                    w_state_d = StWrData;
                end else if (r_tx_full && w_expired) begin
                    w_state_d = StRdCtrl;
                end else if (!r_rx_full && w_expired) begin
                    w_state_d = StRdData;
                end
            end
            default: begin
                if (!bus.avm_waitrequest) begin
                    w_state_d = StIdle;
                end
            end
        endcase
    end

    // Avalon outputs are registered from the next state, so they stay frozen
    // while the slave stalls and drop the cycle after completion.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_chipselect <= 1'b0;
            r_address    <= 1'b0;
            r_read_n     <= 1'b1;
            r_write_n    <= 1'b1;
            r_writedata  <= 32'h0;
        end else begin
            r_chipselect <= (w_state_d != StIdle);
            r_address    <= (w_state_d == StRdCtrl);
            r_read_n     <= !((w_state_d == StRdCtrl) || (w_state_d == StRdData));
            r_write_n    <= (w_state_d != StWrData);
            if (w_state_d == StWrData) begin
                r_writedata <= {24'h0, r_tx_data};
            end
        end
    end

    // Holding registers, wspace cache and poll timer
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_tx_full <= 1'b0;
            r_tx_data <= 8'h0;
            r_rx_full <= 1'b0;
            r_rx_data <= 8'h0;
            r_wspace  <= 16'd0;
            r_timer   <= 16'd0;
        end else begin
            if (w_tx_fire) begin
                r_tx_full <= 1'b1;
                r_tx_data <= bus.tx_data;
            end else if ((r_state == StWrData) && w_done) begin
                r_tx_full <= 1'b0;
            end

            if ((r_state == StRdData) && w_done && w_rvalid) begin
                r_rx_full <= 1'b1;
                r_rx_data <= bus.avm_readdata[7:0];
            end else if (w_rx_pop) begin
                r_rx_full <= 1'b0;
            end

            if ((r_state == StRdCtrl) && w_done) begin
                r_wspace <= w_rd_hi;
            end else if ((r_state == StWrData) && w_done && (r_wspace != 16'd0)) begin
                r_wspace <= r_wspace - 16'd1;
            end

            // Back off only when a poll found nothing; a successful poll
            // leaves the timer expired so the follow-up goes out at once.
            if ((r_state == StRdCtrl) && w_done && (w_rd_hi == 16'd0)) begin
                r_timer <= TimerLoad;
            end else if ((r_state == StRdData) && w_done && !w_rvalid) begin
                r_timer <= TimerLoad;
            end else if (!w_expired) begin
                r_timer <= r_timer - 16'd1;
            end
        end
    end

    assign bus.avm_chipselect = r_chipselect;
    assign bus.avm_address    = r_address;
    assign bus.avm_read_n     = r_read_n;
    assign bus.avm_write_n    = r_write_n;
    assign bus.avm_writedata  = r_writedata;
    assign bus.tx_ready       = !r_tx_full;
    assign bus.rx_valid       = r_rx_full;
    assign bus.rx_data        = r_rx_data;

endmodule

// File: tb/tb_jtag_uart_master.sv
// -----------------------------------------------------------------------------
// tb_jtag_uart_master
// Directed bench for jtag_uart_master: a small JTAG UART slave model with a
// configurable waitrequest stall, a transfer monitor, and one task per scenario.
// -----------------------------------------------------------------------------
module tb_jtag_uart_master;

    logic clk = 1'b0;
    logic reset_reset = 1'b1;

    jtag_uart_master_if bus();

    jtag_uart_master #(.POLL_INTERVAL(64)) dut (
        .clk_clk     (clk),
        .reset_reset (reset_reset),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Slave model configuration
    int          stall_cycles = 0;
    logic [15:0] slv_wspace   = 16'd0;
    logic [15:0] slv_ravail   = 16'd0;
    logic        slv_rvalid   = 1'b0;
    logic [7:0]  slv_rbyte    = 8'h0;

    // Monitor state
    int          cyc = 0;
    int          stall_cnt = 0;
    logic        prev_req = 1'b0;
    int          n_rd_data_start = 0, n_rd_data_done = 0;
    int          n_rd_ctrl_start = 0, n_rd_ctrl_done = 0;
    int          n_wr_start = 0, n_wr_done = 0;
    int          rd_data_start_cyc = 0, rd_data_done_cyc = 0;
    int          ctrl_start_cyc = 0, ctrl_done_cyc = 0;
    int          wr_start_cyc = 0;
    logic [31:0] last_wdata = 32'h0;

    logic req;
    assign req = bus.avm_chipselect && (!bus.avm_read_n || !bus.avm_write_n);
    assign bus.avm_waitrequest = req && (stall_cnt < stall_cycles);
    assign bus.avm_readdata = bus.avm_address ? {slv_wspace, 16'h0}
                                              : {slv_ravail, slv_rvalid, 7'h0, slv_rbyte};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        prev_req <= req;
        if (req && bus.avm_waitrequest) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
        if (req && !prev_req) begin
            if (!bus.avm_write_n) begin
                n_wr_start <= n_wr_start + 1; wr_start_cyc <= cyc;
            end else if (bus.avm_address) begin
                n_rd_ctrl_start <= n_rd_ctrl_start + 1; ctrl_start_cyc <= cyc;
            end else begin
                n_rd_data_start <= n_rd_data_start + 1; rd_data_start_cyc <= cyc;
            end
        end
        if (req && !bus.avm_waitrequest) begin
            if (!bus.avm_write_n) begin
                n_wr_done <= n_wr_done + 1; last_wdata <= bus.avm_writedata;
            end else if (bus.avm_address) begin
                n_rd_ctrl_done <= n_rd_ctrl_done + 1; ctrl_done_cyc <= cyc;
            end else begin
                n_rd_data_done <= n_rd_data_done + 1; rd_data_done_cyc <= cyc;
            end
        end
    end

    task automatic do_reset();
        reset_reset = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h0;
        bus.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.tx_valid = 1'b1;
        bus.tx_data = b;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h0;
        bus.rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.avm_chipselect, bus.avm_read_n, bus.avm_write_n, bus.avm_address} !== 4'b0110) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=0110", {bus.avm_chipselect, bus.avm_read_n,
                     bus.avm_write_n, bus.avm_address});
        end
        checks++;
        if (bus.avm_writedata !== 32'h0) begin
            failures++; $display("FAIL reset_wdata got=%h exp=00000000", bus.avm_writedata);
        end
        checks++;
        if ({bus.tx_ready, bus.rx_valid, bus.rx_data} !== {1'b1, 1'b0, 8'h00}) begin
            failures++; $display("FAIL reset_streams got=%b/%b/%h exp=1/0/00", bus.tx_ready,
                                 bus.rx_valid, bus.rx_data);
        end
        reset_reset = 1'b0;
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release_tx_ready got=%b exp=1", bus.tx_ready);
        end
        // Timer starts expired and rx is empty: a data poll goes out at once.
        @(negedge clk);
        checks++;
        if ({bus.avm_chipselect, bus.avm_read_n, bus.avm_address} !== 3'b100) begin
            failures++; $display("FAIL reset_first_poll got=%b exp=100",
                                 {bus.avm_chipselect, bus.avm_read_n, bus.avm_address});
        end
    endtask

    task automatic test_rx_empty_poll();
        int base, t, d;
        slv_rvalid = 1'b0;
        do_reset();
        base = n_rd_data_done;
        t = 0;
        while (n_rd_data_done < base + 1 && t < 20) begin @(negedge clk); t++; end
        d = rd_data_done_cyc;
        t = 0;
        while (n_rd_data_done < base + 2 && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (n_rd_data_done < base + 2) begin
            failures++; $display("FAIL empty_poll_timeout got=%0d exp=%0d", n_rd_data_done, base + 2);
        end
        // Completion edge to first sampled strobe of the next poll: 64 idle + 1
        checks++;
        if (rd_data_start_cyc - d !== 65) begin
            failures++; $display("FAIL empty_poll_gap got=%0d exp=65", rd_data_start_cyc - d);
        end
    endtask

    task automatic test_tx_basic();
        int bw, bc, t;
        slv_wspace = 16'd64;
        slv_rvalid = 1'b0;
        do_reset();
        bw = n_wr_done;
        bc = n_rd_ctrl_done;
        send_byte(8'h41);
        checks++;
        if (bus.tx_ready !== 1'b0) begin
            failures++; $display("FAIL tx_ready_after_accept got=%b exp=0", bus.tx_ready);
        end
        t = 0;
        while (n_wr_done == bw && t < 300) begin @(negedge clk); t++; end
        checks++;
        if (n_wr_done - bw !== 1) begin
            failures++; $display("FAIL tx_write_count got=%0d exp=1", n_wr_done - bw);
        end
        checks++;
        if (n_rd_ctrl_done - bc !== 1) begin
            failures++; $display("FAIL tx_ctrl_count got=%0d exp=1", n_rd_ctrl_done - bc);
        end
        checks++;
        if (last_wdata !== 32'h00000041) begin
            failures++; $display("FAIL tx_wdata got=%h exp=00000041", last_wdata);
        end
        checks++;
        if (wr_start_cyc - ctrl_done_cyc !== 2) begin
            failures++; $display("FAIL tx_write_latency got=%0d exp=2", wr_start_cyc - ctrl_done_cyc);
        end
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            failures++; $display("FAIL tx_ready_after_write got=%b exp=1", bus.tx_ready);
        end
        checks++;
        if (dut.r_wspace !== 16'd63) begin
            failures++; $display("FAIL tx_wspace got=%0d exp=63", dut.r_wspace);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (n_wr_done - bw !== 1) begin
            failures++; $display("FAIL tx_no_extra_write got=%0d exp=1", n_wr_done - bw);
        end
    endtask

    task automatic test_rx_data();
        int base, t;
        slv_rvalid = 1'b1;
        slv_rbyte = 8'h55;
        slv_ravail = 16'd3;
        do_reset();
        t = 0;
        while (bus.rx_valid !== 1'b1 && t < 10) begin @(negedge clk); t++; end
        slv_rvalid = 1'b0;
        checks++;
        if ({bus.rx_valid, bus.rx_data} !== {1'b1, 8'h55}) begin
            failures++; $display("FAIL rx_capture got=%b/%h exp=1/55", bus.rx_valid, bus.rx_data);
        end
        base = n_rd_data_start;
        repeat (100) @(negedge clk);
        checks++;
        if (n_rd_data_start - base !== 0) begin
            failures++; $display("FAIL rx_hold_no_read got=%0d exp=0", n_rd_data_start - base);
        end
        checks++;
        if ({bus.rx_valid, bus.rx_data} !== {1'b1, 8'h55}) begin
            failures++; $display("FAIL rx_hold got=%b/%h exp=1/55", bus.rx_valid, bus.rx_data);
        end
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        checks++;
        if ({bus.rx_valid, bus.avm_read_n} !== 2'b01) begin
            failures++; $display("FAIL rx_pop got=%b exp=01", {bus.rx_valid, bus.avm_read_n});
        end
        @(negedge clk);
        checks++;
        if ({bus.avm_chipselect, bus.avm_read_n, bus.avm_address} !== 3'b100) begin
            failures++; $display("FAIL rx_next_read_immediate got=%b exp=100",
                                 {bus.avm_chipselect, bus.avm_read_n, bus.avm_address});
        end
    endtask

    task automatic test_waitrequest();
        int bw, t, cnt;
        slv_wspace = 16'd64;
        slv_rvalid = 1'b0;
        stall_cycles = 5;
        do_reset();
        bw = n_wr_done;
        send_byte(8'hA5);
        t = 0;
        while (bus.avm_write_n !== 1'b0 && t < 400) begin @(negedge clk); t++; end
        cnt = 0;
        while (bus.avm_write_n === 1'b0 && cnt < 20) begin
            checks++;
            if ({bus.avm_chipselect, bus.avm_address, bus.avm_write_n, bus.avm_read_n,
                 bus.avm_writedata} !== {4'b1001, 32'h000000A5}) begin
                failures++;
                $display("FAIL wait_stable cyc%0d got=%b%b%b%b/%h exp=1001/000000a5", cnt,
                         bus.avm_chipselect, bus.avm_address, bus.avm_write_n, bus.avm_read_n,
                         bus.avm_writedata);
            end
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== 6) begin
            failures++; $display("FAIL wait_strobe_cycles got=%0d exp=6", cnt);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (n_wr_done - bw !== 1 || last_wdata !== 32'h000000A5) begin
            failures++; $display("FAIL wait_single_write got=%0d/%h exp=1/000000a5",
                                 n_wr_done - bw, last_wdata);
        end
        stall_cycles = 0;
    endtask

    task automatic test_wspace_zero();
        int bw, bc, t, d;
        slv_wspace = 16'd0;
        slv_rvalid = 1'b0;
        do_reset();
        bw = n_wr_done;
        bc = n_rd_ctrl_done;
        send_byte(8'h3C);
        t = 0;
        while (n_rd_ctrl_done < bc + 1 && t < 200) begin @(negedge clk); t++; end
        d = ctrl_done_cyc;
        t = 0;
        while (n_rd_ctrl_done < bc + 2 && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (ctrl_start_cyc - d !== 65) begin
            failures++; $display("FAIL ws0_poll_gap got=%0d exp=65", ctrl_start_cyc - d);
        end
        t = 0;
        while (n_rd_ctrl_done < bc + 3 && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (n_wr_done - bw !== 0) begin
            failures++; $display("FAIL ws0_no_write got=%0d exp=0", n_wr_done - bw);
        end
        slv_wspace = 16'd1;
        t = 0;
        while (n_wr_done == bw && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (n_wr_done - bw !== 1 || last_wdata !== 32'h0000003C) begin
            failures++; $display("FAIL ws0_write got=%0d/%h exp=1/0000003c", n_wr_done - bw,
                                 last_wdata);
        end
        checks++;
        if (n_rd_ctrl_done - bc !== 4) begin
            failures++; $display("FAIL ws0_ctrl_count got=%0d exp=4", n_rd_ctrl_done - bc);
        end
        checks++;
        if (dut.r_wspace !== 16'd0) begin
            failures++; $display("FAIL ws0_wspace got=%0d exp=0", dut.r_wspace);
        end
    endtask

    task automatic test_reset_midread();
        slv_rvalid = 1'b0;
        stall_cycles = 1000;
        do_reset();
        send_byte(8'h77);
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.avm_chipselect, bus.avm_read_n, bus.tx_ready} !== 3'b100) begin
            failures++; $display("FAIL midread_stalled got=%b exp=100",
                                 {bus.avm_chipselect, bus.avm_read_n, bus.tx_ready});
        end
        reset_reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.avm_chipselect, bus.avm_read_n} !== 2'b01) begin
            failures++; $display("FAIL midread_abort got=%b exp=01",
                                 {bus.avm_chipselect, bus.avm_read_n});
        end
        stall_cycles = 0;
        repeat (2) @(negedge clk);
        reset_reset = 1'b0;
        checks++;
        if ({bus.rx_valid, bus.tx_ready} !== 2'b01) begin
            failures++; $display("FAIL midread_release got=%b exp=01", {bus.rx_valid, bus.tx_ready});
        end
    endtask

    initial begin
        bus.tx_valid = 1'b0;
        bus.tx_data = 8'h0;
        bus.rx_ready = 1'b0;
        test_reset();
        test_rx_empty_poll();
        test_tx_basic();
        test_rx_data();
        test_waitrequest();
        test_wspace_zero();
        test_reset_midread();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jtag_uart_master.md
JTAG_UART_MASTER -- requirements
Module: jtag_uart_master

Interface
REQ-001 Parameter POLL_INTERVAL, default 64: idle cycles between status polls when no data or space is found; range 2..65535.
REQ-002 clk_clk  input  1  single system clock; all logic on its rising edge.
REQ-003 reset_reset  input  1  synchronous, active-high reset.
REQ-004 avm_chipselect  output  1  Avalon-MM chipselect to the JTAG UART slave.
REQ-005 avm_address  output  1  0 = data register, 1 = control register.
REQ-006 avm_read_n  output  1  active-low read strobe.
REQ-007 avm_readdata  input  32  slave read data; valid in the cycle avm_waitrequest is low.
REQ-008 avm_write_n  output  1  active-low write strobe.
REQ-009 avm_writedata  output  32  write data; bits [7:0] carry the byte, [31:8] are 0.
REQ-010 avm_waitrequest  input  1  slave stall; a transfer completes in the first strobed cycle with it low.
REQ-011 tx_data  input  8  byte to send to the host.
REQ-012 tx_valid  input  1  tx_data valid.
REQ-013 tx_ready  output  1  tx holding register empty; a byte is accepted when tx_valid&tx_ready at a clock edge.
REQ-014 rx_data  output  8  byte received from the host.
REQ-015 rx_valid  output  1  rx holding register full.
REQ-016 rx_ready  input  1  consumer accepts; a byte is popped when rx_valid&rx_ready at a clock edge.

Function
REQ-017 Slave register map: data reg read = [7:0] byte, [15] RVALID, [31:16] RAVAIL, and the read pops the byte; data reg write [7:0] transmits; control reg read [31:16] = WSPACE.
REQ-018 One-entry tx holding register (tx_full) and one-entry rx holding register (rx_full); tx_ready = !tx_full; rx_valid = rx_full.
REQ-019 16-bit wspace counter caches free TX FIFO space: loaded from readdata[31:16] on a completed control read, decremented by 1 on each completed data write, never wraps below 0.
REQ-020 16-bit poll timer: loads POLL_INTERVAL-1 when armed, decrements to 0 and holds; "expired" = 0.
REQ-021 FSM states: IDLE, WR_DATA, RD_CTRL, RD_DATA; all Avalon outputs are registered from the state.
REQ-022 IDLE priority, evaluated each cycle: (1) tx_full and wspace>0 -> WR_DATA; (2) tx_full, wspace==0, timer expired -> RD_CTRL; (3) !rx_full and timer expired -> RD_DATA; else stay.
REQ-023 WR_DATA: chipselect=1, address=0, write_n=0, writedata={24'h0,tx byte}; held unchanged while waitrequest=1.
REQ-024 RD_CTRL / RD_DATA: chipselect=1, read_n=0, address=1 / 0 respectively; held unchanged while waitrequest=1.
REQ-025 On completion the FSM returns to IDLE, and the strobes are deasserted in the next cycle; this gives at least one idle bus cycle between transfers.
REQ-026 WR_DATA completion: tx_full cleared and wspace decremented at the same edge; tx_ready=1 the following cycle.
REQ-027 RD_CTRL completion: wspace loaded; the timer is armed when the loaded value is 0, and left expired otherwise.
REQ-028 RD_DATA completion:
- RVALID=1: rx byte captured, rx_full set, timer left expired so the next read is immediate once the byte is popped.
- RVALID=0: rx_full unchanged, timer armed.
REQ-029 RD_DATA is never issued while rx_full=1, so no host byte is ever dropped.
REQ-030 Worst-case latency from IDLE with tx_full and wspace>0 to write_n low is 1 cycle.
REQ-031 Bytes are delivered to the Avalon bus in tx acceptance order.

Reset
REQ-032 While reset_reset=1 at an edge, the following are forced, including mid-transfer:
- chipselect=0, read_n=1, write_n=1, address=0, writedata=0;
- tx_full=0, rx_full=0, rx_data=0, wspace=0, timer=0, state=IDLE.
REQ-033 A byte held in either holding register at reset is discarded; tx_ready=1 in the first cycle after reset deasserts.

Verification
REQ-034 After reset, slave reports WSPACE=64; tx_valid with 0x41 -> one control read at address 1, then one write with writedata=0x00000041; wspace ends at 63.
REQ-035 Slave returns 0x0003_8055 on a data read -> rx_valid=1 with rx_data=0x55; no further data read is issued until rx_ready pops the byte, and the next read then follows immediately.
REQ-036 Slave returns RVALID=0 with POLL_INTERVAL=64 -> the next data read starts no earlier than 64 cycles after completion.
REQ-037 waitrequest held high 5 cycles during a write of 0xA5 -> chipselect, write_n, address and writedata remain stable for all 6 cycles; exactly one byte is written.
REQ-038 WSPACE=0 with tx_full -> no write is issued and control polls repeat every POLL_INTERVAL cycles; the write goes out after WSPACE=1 is returned.
REQ-039 reset_reset asserted during a stalled read -> chipselect=0 and read_n=1 at the next edge; rx_valid=0 and tx_ready=1 after release.
